pfpu_wb: RTL and testbench

Write-back stage of the PFPU datapath. Sits directly downstream of the ALU units (comparator, adder, multiplier, converter). It tracks in-flight destination register addresses in a latency-aligned tag pipeline, selects the result of whichever unit completes, and issues a registered write to the register file. It also reports issue collisions and pipeline idle to the sequencer.

---
 rtl/pfpu_wb.sv | 147 ++++++++++++++
 tb/tb_pfpu_wb.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pfpu_wb.sv
// PFPU write-back stage: latency-aligned tag pipeline selecting the completing unit's result.
// Optional protocol checker enabled by defining PFPU_WB_CHECK_EN.
module pfpu_wb #(
    parameter int unsigned MAXLAT = 8,
    parameter int unsigned LAT0   = 1,
    parameter int unsigned LAT1   = 1,
    parameter int unsigned LAT2   = 4,
    parameter int unsigned LAT3   = 5
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        alu_rst,
    input  logic        issue_valid,
    input  logic [1:0]  issue_unit,
    input  logic [6:0]  issue_dest,
    output logic        collide,
    input  logic [3:0]  u_valid,
    input  logic [31:0] u_r0,
    input  logic [31:0] u_r1,
    input  logic [31:0] u_r2,
    input  logic [31:0] u_r3,
    output logic        regf_we,
    output logic [6:0]  regf_adr,
    output logic [31:0] regf_dat,
    output logic        idle,
    output logic        err
);

    typedef struct packed {
        logic       valid;
        logic [1:0] unit;
        logic [6:0] dest;
    } tag_t;

    tag_t        slot_q [MAXLAT];
    tag_t        slot_d [MAXLAT];
    logic        regf_we_q,  regf_we_d;
    logic [6:0]  regf_adr_q, regf_adr_d;
    logic [31:0] regf_dat_q, regf_dat_d;
    logic        idle_q,     idle_d;

    int unsigned iss_lat;
    logic        lat_ok;
    logic        occupied;
    logic        accept;
    logic [31:0] wb_res;
    logic        any_valid;

    // Issue decode: the slot at index L is the one that would shift into the insert position.
    always_comb begin
        case (issue_unit)
            2'd0:    iss_lat = LAT0;
            2'd1:    iss_lat = LAT1;
            2'd2:    iss_lat = LAT2;
            default: iss_lat = LAT3;
        endcase
        lat_ok   = (iss_lat >= 32'd1) && (iss_lat <= MAXLAT);
        occupied = 1'b0;
        for (int unsigned i = 0; i < MAXLAT; i++) begin
            if (i == iss_lat) occupied = slot_q[i].valid;
        end
    end

    assign collide = issue_valid && occupied;
    assign accept  = issue_valid && !collide && !alu_rst;

    always_comb begin
        case (slot_q[0].unit)
            2'd0:    wb_res = u_r0;
            2'd1:    wb_res = u_r1;
            2'd2:    wb_res = u_r2;
            default: wb_res = u_r3;
        endcase
    end

    always_comb begin
        for (int unsigned i = 0; i < MAXLAT - 1; i++) begin
            slot_d[i] = slot_q[i+1];
        end
        slot_d[MAXLAT-1] = '0;
        for (int unsigned i = 0; i < MAXLAT; i++) begin
            if (accept && lat_ok && (i + 32'd1 == iss_lat)) begin
                slot_d[i] = '{valid: 1'b1, unit: issue_unit, dest: issue_dest};
            end
        end

        regf_we_d  = slot_q[0].valid;
        regf_adr_d = slot_q[0].valid ? slot_q[0].dest : regf_adr_q;
        regf_dat_d = slot_q[0].valid ? wb_res : regf_dat_q;

        if (alu_rst) begin
            for (int unsigned i = 0; i < MAXLAT; i++) slot_d[i] = '0;
            regf_we_d  = 1'b0;
            regf_adr_d = 7'd0;
            regf_dat_d = 32'd0;
        end

        any_valid = 1'b0;
        for (int unsigned i = 0; i < MAXLAT; i++) any_valid = any_valid | slot_d[i].valid;
        idle_d = !any_valid && !regf_we_d;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int unsigned i = 0; i < MAXLAT; i++) slot_q[i] <= '0;
            regf_we_q  <= 1'b0;
            regf_adr_q <= 7'd0;
            regf_dat_q <= 32'd0;
            idle_q     <= 1'b1;
        end else begin
            for (int unsigned i = 0; i < MAXLAT; i++) slot_q[i] <= slot_d[i];
            regf_we_q  <= regf_we_d;
            regf_adr_q <= regf_adr_d;
            regf_dat_q <= regf_dat_d;
            idle_q     <= idle_d;
        end
    end

    assign regf_we  = regf_we_q;
    assign regf_adr = regf_adr_q;
    assign regf_dat = regf_dat_q;
    assign idle     = idle_q;

`ifdef PFPU_WB_CHECK_EN
    logic       err_q, err_d;
    logic [3:0] exp_valid;

    // Unit completions must match the tag exactly; unsupported latencies are also flagged.
    always_comb begin
        exp_valid = slot_q[0].valid ? (4'b0001 << slot_q[0].unit) : 4'b0000;
        err_d     = err_q | (u_valid != exp_valid) | (issue_valid && !collide && !lat_ok);
        if (alu_rst) err_d = 1'b0;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) err_q <= 1'b0;
        else            err_q <= err_d;
    end

    assign err = err_q;
`else
    logic unused_uvalid;
    assign unused_uvalid = ^u_valid;
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_pfpu_wb.sv
// Directed self-checking bench for pfpu_wb (default latencies 1/1/4/5, MAXLAT 8).
module tb_pfpu_wb;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        alu_rst;
    logic        issue_valid;
    logic [1:0]  issue_unit;
    logic [6:0]  issue_dest;
    logic        collide;
    logic [3:0]  u_valid;
    logic [31:0] u_r0, u_r1, u_r2, u_r3;
    logic        regf_we;
    logic [6:0]  regf_adr;
    logic [31:0] regf_dat;
    logic        idle;
    logic        err;

    int checks = 0;
    int errors = 0;

    pfpu_wb dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .alu_rst    (alu_rst),
        .issue_valid(issue_valid),
        .issue_unit (issue_unit),
        .issue_dest (issue_dest),
        .collide    (collide),
        .u_valid    (u_valid),
        .u_r0       (u_r0),
        .u_r1       (u_r1),
        .u_r2       (u_r2),
        .u_r3       (u_r3),
        .regf_we    (regf_we),
        .regf_adr   (regf_adr),
        .regf_dat   (regf_dat),
        .idle       (idle),
        .err        (err)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to the start of the next cycle; inputs change and outputs are sampled here.
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic idle_in();
        issue_valid = 1'b0;
        issue_unit  = 2'd0;
        issue_dest  = 7'd0;
        u_valid     = 4'b0000;
        alu_rst     = 1'b0;
    endtask

    task automatic issue(input logic [1:0] unit, input logic [6:0] dest);
        issue_valid = 1'b1;
        issue_unit  = unit;
        issue_dest  = dest;
    endtask

    task automatic chk_wr(input string tag, input logic [6:0] adr, input logic [31:0] dat);
        chk({tag, "_we"},  32'(regf_we),  32'd1);
        chk({tag, "_adr"}, 32'(regf_adr), 32'(adr));
        chk({tag, "_dat"}, regf_dat, dat);
    endtask

    initial begin
        sys_rst_n = 1'b0;
        idle_in();
        u_r0 = 32'h0; u_r1 = 32'h0; u_r2 = 32'h0; u_r3 = 32'h0;
        repeat (3) tick();
        chk("rst_we",      32'(regf_we),  32'd0);
        chk("rst_adr",     32'(regf_adr), 32'd0);
        chk("rst_dat",     regf_dat,      32'd0);
        chk("rst_idle",    32'(idle),     32'd1);
        chk("rst_err",     32'(err),      32'd0);
        chk("rst_collide", 32'(collide),  32'd0);
        sys_rst_n = 1'b1;
        tick();

        // Single op: unit 0, L=1.
        issue(2'd0, 7'h12);
        #1 chk("single_collide", 32'(collide), 32'd0);
        tick();
        idle_in(); u_valid = 4'b0001; u_r0 = 32'h3f800000;
        chk("single_t1_we",   32'(regf_we), 32'd0);
        chk("single_t1_idle", 32'(idle),    32'd0);
        tick();
        u_valid = 4'b0000; u_r0 = 32'hdeadbeef;
        chk_wr("single_t2", 7'h12, 32'h3f800000);
        tick();
        chk("single_t3_we",   32'(regf_we),  32'd0);
        chk("single_t3_idle", 32'(idle),     32'd1);
        chk("single_t3_adr",  32'(regf_adr), 32'h12);
        chk("single_t3_dat",  regf_dat,      32'h3f800000);

        // Interleave: unit 3 at t, unit 2 at t+2.
        issue(2'd3, 7'd5);
        tick(); idle_in();
        tick(); issue(2'd2, 7'd6);
        #1 chk("inter_collide", 32'(collide), 32'd0);
        tick(); idle_in();
        tick();
        tick(); u_valid = 4'b1000; u_r3 = 32'haaaa0005;
        tick(); u_valid = 4'b0100; u_r2 = 32'hbbbb0006; u_r3 = 32'h0;
        chk_wr("inter_t6", 7'd5, 32'haaaa0005);
        tick(); u_valid = 4'b0000; u_r2 = 32'h0;
        chk_wr("inter_t7", 7'd6, 32'hbbbb0006);
        tick();
        chk("inter_t8_we",   32'(regf_we), 32'd0);
        chk("inter_t8_idle", 32'(idle),    32'd1);

        // Collision: unit 3 at t, unit 2 at t+1 lands on the same completion cycle.
        issue(2'd3, 7'd7);
        tick(); issue(2'd2, 7'd8);
        #1 chk("coll_collide", 32'(collide), 32'd1);
        tick(); idle_in();
        #1 chk("coll_clear", 32'(collide), 32'd0);
        tick();
        tick();
        tick(); u_valid = 4'b1000; u_r3 = 32'h000000cc; u_r2 = 32'h000000dd;
        tick(); u_valid = 4'b0000;
        chk_wr("coll_t6", 7'd7, 32'h000000cc);
        tick();
        chk("coll_t7_we",   32'(regf_we), 32'd0);
        chk("coll_t7_idle", 32'(idle),    32'd1);

        // Back-to-back L=1 units in consecutive cycles, issue overlapping a write-back.
        issue(2'd0, 7'd1);
        tick(); issue(2'd1, 7'd2); u_valid = 4'b0001; u_r0 = 32'h11111111;
        #1 chk("b2b_collide", 32'(collide), 32'd0);
        tick(); idle_in(); u_valid = 4'b0010; u_r1 = 32'h22222222;
        chk_wr("b2b_t2", 7'd1, 32'h11111111);
        tick(); u_valid = 4'b0000;
        chk_wr("b2b_t3", 7'd2, 32'h22222222);
        tick();
        chk("b2b_t4_we", 32'(regf_we), 32'd0);

        // Flush: unit 3 at t, alu_rst at t+2 with a concurrent issue that must be discarded.
        issue(2'd3, 7'd9);
        tick(); idle_in();
        tick(); alu_rst = 1'b1; issue(2'd0, 7'd10);
        tick(); idle_in();
        chk("flush_t3_idle", 32'(idle),     32'd1);
        chk("flush_t3_we",   32'(regf_we),  32'd0);
        chk("flush_t3_adr",  32'(regf_adr), 32'd0);
        chk("flush_t3_dat",  regf_dat,      32'd0);
        for (int k = 4; k <= 7; k++) begin
            if (k == 5) u_r3 = 32'h99999999;
            tick();
            chk($sformatf("flush_t%0d_we", k), 32'(regf_we), 32'd0);
            chk($sformatf("flush_t%0d_idle", k), 32'(idle), 32'd1);
        end
        chk("flush_err", 32'(err), 32'd0);

        // Wrong unit reports completion: sticky err only with checking enabled.
        issue(2'd0, 7'd3);
        tick(); idle_in(); u_valid = 4'b0010; u_r0 = 32'h33333333;
        tick(); u_valid = 4'b0000;
        chk_wr("chk_t2", 7'd3, 32'h33333333);
`ifdef PFPU_WB_CHECK_EN
        chk("chk_err_t2", 32'(err), 32'd1);
        repeat (3) tick();
        chk("chk_err_held", 32'(err), 32'd1);
        alu_rst = 1'b1;
        tick(); alu_rst = 1'b0;
        chk("chk_err_clr", 32'(err), 32'd0);
`else
        chk("chk_err_t2", 32'(err), 32'd0);
        repeat (3) tick();
        chk("chk_err_held", 32'(err), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
